// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: assembles framed serial bits into WIDTH-bit words
// and holds each finished word in a one-entry valid/ready buffer with sticky error flags.
//
// state | meaning
// IDLE  | waiting for a bit qualified by frame_start
// SHIFT | frame partially received, cnt bits collected so far
module shift_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clear_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             buf_free;

  // The first bit is placed so that WIDTH-1 further shifts walk it to its final position.
  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {sr_q[WIDTH-2:0], ser_in};
      first_bit = {{(WIDTH-1){1'b0}}, ser_in};
    end else begin
      shifted   = {ser_in, sr_q[WIDTH-1:1]};
      first_bit = {ser_in, {(WIDTH-1){1'b0}}};
    end
  end

  assign buf_free = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q & ~out_ready;
    overrun_d   = overrun_q & ~clear_err;
    frame_err_d = frame_err_q & ~clear_err;

    if (ser_valid) begin
      if (frame_start) begin
        if (state_q == SHIFT) frame_err_d = 1'b1;
        sr_d    = first_bit;
        cnt_d   = CNT_ONE;
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        sr_d = shifted;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (buf_free) begin
            data_out_d  = shifted;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in/parallel-out receiver for the shift datapath. It collects a framed serial bit stream into WIDTH-bit words, in a selectable bit order. Each completed word is presented on a one-entry valid/ready output buffer. Error flags are sticky. It is the receive end of the serial link whose words feed the parallel shift logic.

## Interface
- WIDTH, 4: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ser_in  in  1  serial data bit, sampled only when ser_valid=1.
- ser_valid  in  1  bit strobe: one bit is accepted per clk edge with ser_valid=1.
- frame_start  in  1  qualified by ser_valid; marks the current bit as bit 0 of a new word.
- data_out  out  WIDTH  assembled word, held stable while out_valid=1.
- out_valid  out  1  data_out holds an unconsumed word.
- out_ready  in  1  consumer accepts the word on an edge where out_valid=1 and out_ready=1.
- busy  out  1  a frame is partially received.
- overrun  out  1  sticky: a completed word was dropped because the buffer was full.
- frame_err  out  1  sticky: frame_start arrived mid-frame.
- clear_err  in  1  synchronous clear of overrun and frame_err.

## Operation
- States: IDLE, SHIFT.
- Internal registers: shift register sr[WIDTH-1:0] and bit counter cnt with width ceil(log2(WIDTH))+1.
- IDLE:
  - ser_valid=1 with frame_start=1: load bit 0, cnt=1, go to SHIFT.
  - ser_valid=1 with frame_start=0: bit ignored.
- SHIFT, on each ser_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}.
  - cnt increments.
- Completion: the edge that accepts bit WIDTH-1 completes the word.
  - The assembled value (sr updated with that bit) goes to data_out if the buffer is free.
  - cnt returns to 0 and the state returns to IDLE.
- Buffer is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge (simultaneous consume and fill is allowed, with no bubble).
- Buffer full at completion: new word is discarded, data_out and out_valid are unchanged, overrun is set to 1.
- frame_start=1 with ser_valid=1 while in SHIFT (cnt ≥ 1):
  - partial word is discarded and frame_err is set;
  - this bit becomes bit 0 of a new frame, with cnt=1.
- ser_valid=0: no state change; gaps between bits of any length are legal.
- out_valid clears on an accept edge unless a new word completes on the same edge.
- clear_err=1 clears both flags. If the same edge also sets a flag, the set wins.
- busy = (state == SHIFT).

## Timing
- Reset (asynchronous assert, synchronous to clk on release):
  - state=IDLE, sr=0, cnt=0.
  - data_out=0, out_valid=0, busy=0, overrun=0, frame_err=0.
- Latency: out_valid rises on the same clk edge that samples the last bit, so it is visible 0 cycles after that edge.
- Throughput: one bit per clk. Back-to-back words are allowed: frame_start may accompany the first bit on the cycle right after completion.
- Reset asserted mid-frame aborts everything. No flag is set and no partial word is emitted.
- All outputs are registered.
- busy falls on the completion edge.

## Test plan
- MSB_FIRST=1, WIDTH=4: send 1,1,0,1 with frame_start on the first bit and out_ready=0 → out_valid=1 after the 4th bit edge, data_out=4'hD. Then out_ready=1 for 1 cycle → out_valid=0.
- MSB_FIRST=0, WIDTH=4: send 1,1,0,1 → data_out=4'hB, no flags set.
- Backpressure: hold out_ready=0, send 4'hD then 4'h6 → data_out stays 4'hD, overrun=1, frame_err=0. Then clear_err=1 → overrun=0.
- Simultaneous consume and fill: out_ready=1 on exactly the edge where the second word (4'h6) completes → out_valid stays 1, data_out=4'h6, overrun=0.
- Mid-frame restart: send 1,0 then frame_start with 0,1,1,1 → frame_err=1, data_out=4'h7.
- Reset mid-frame: 2 bits in, pulse rst_n low, then send a full 4'h9 frame → data_out=4'h9, all flags 0, busy=0 during the reset pulse.
